// File: rtl/piho_pkg.sv
// Shared types and constants for the piho result collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piho_pkg;

  localparam int         RECORD_W      = 128;
  localparam int         FRAME_BYTES   = 18;
  localparam int         PAYLOAD_BYTES = 16;
  localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } ser_state_t;

  // looptimes sits in the low bits so the payload shifts out little-endian
  // in frame order: looptimes, first, last, x2sum.
  typedef struct packed {
    logic [31:0] x2sum;
    logic [31:0] last;
    logic [31:0] first;
    logic [31:0] looptimes;
  } record_t;

endpackage

// File: rtl/piho_record_fifo.sv
// Synchronous record FIFO with occupancy count.
// Latency: pushed entry visible at the head the cycle after push.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module piho_record_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; when full with a pop, the slot written is the one being read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/piho_result_collector.sv
// Captures piho_unit results on finish rising edge and streams them as 18-byte checksummed frames.
// Latency: capture -> header byte valid in 2 cycles when idle and empty; one idle bubble between frames.
// Backpressure: out_valid/out_data held until out_ready; records arriving to a full FIFO are dropped (sticky overflow).
// Optional: PIHO_RESULT_COLLECTOR_ACCUM_EN adds clr_acc, x2acc and acc_count.
module piho_result_collector
  import piho_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  localparam int        LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          finish,
  input  logic [31:0]   looptimes,
  input  logic [31:0]   first,
  input  logic [31:0]   last,
  input  logic [31:0]   x2sum,
`ifdef PIHO_RESULT_COLLECTOR_ACCUM_EN
  input  logic          clr_acc,
  output logic [63:0]   x2acc,
  output logic [31:0]   acc_count,
`endif
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic [15:0]   frames_sent,
  output logic          busy
);

  logic                finish_d;
  logic                capture;
  record_t             rec_in;
  logic [RECORD_W-1:0] rec_out;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                hs;
  ser_state_t          state;
  logic [RECORD_W-1:0] shreg;
  logic [7:0]          csum;
  logic [7:0]          csum_next;
  logic [3:0]          idx;

  assign capture          = finish & ~finish_d;
  assign rec_in.looptimes = looptimes;
  assign rec_in.first     = first;
  assign rec_in.last      = last;
  assign rec_in.x2sum     = x2sum;
  assign pop              = (state == ST_IDLE) & ~fifo_empty;
  assign hs               = out_valid & out_ready;
  assign csum_next        = csum + out_data;
  assign busy             = (state != ST_IDLE);

  piho_record_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_dat (rec_in),
    .pop      (pop),
    .pop_dat  (rec_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Edge detect history and sticky drop flag (drop only when no pop frees a slot).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_d <= 1'b0;
      overflow <= 1'b0;
    end else begin
      finish_d <= finish;
      if (capture && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Frame serializer: outputs are registered so they stay stable across stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      csum        <= '0;
      idx         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg     <= rec_out;
            csum      <= '0;
            out_data  <= SYNC_BYTE;
            out_valid <= 1'b1;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hs) begin
            csum     <= SYNC_BYTE;
            idx      <= '0;
            out_data <= shreg[7:0];
            shreg    <= shreg >> 8;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (hs) begin
            csum <= csum_next;
            idx  <= idx + 4'd1;
            if (idx == 4'(PAYLOAD_BYTES - 1)) begin
              out_data <= ~csum_next;
              state    <= ST_CSUM;
            end else begin
              out_data <= shreg[7:0];
              shreg    <= shreg >> 8;
            end
          end
        end
        ST_CSUM: begin
          if (hs) begin
            frames_sent <= frames_sent + 16'd1;
            out_data    <= '0;
            out_valid   <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PIHO_RESULT_COLLECTOR_ACCUM_EN
  // Running x2sum total over every capture, dropped records included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x2acc     <= '0;
      acc_count <= '0;
    end else if (clr_acc) begin
      x2acc     <= capture ? {32'd0, x2sum} : 64'd0;
      acc_count <= capture ? 32'd1 : 32'd0;
    end else if (capture) begin
      x2acc     <= x2acc + {32'd0, x2sum};
      acc_count <= acc_count + 32'd1;
    end
  end
`endif

endmodule
